// File: rtl/cosine_pkg.sv
// rtl/cosine_pkg.sv - shared state codes and constants for the cosine datapath and controller
package cosine_pkg;

  localparam int STATE_W      = 4;
  localparam int SERIES_TERMS = 8;
  // Fixed-point 1.0 (5 integer bits, 11 fraction bits) used by the datapath term register
  localparam logic [15:0] ONE = 16'b00001_00000000000;

  typedef enum logic [3:0] {
    STANDBY    = 4'd0,
    ALERT      = 4'd1,
    START_CALC = 4'd2,
    ACCUM      = 4'd3,
    CALC_DIST  = 4'd4,
    REMULT     = 4'd5,
    REPORT     = 4'd6
  } state_e;

endpackage

// File: rtl/cosine_down_counter.sv
// rtl/cosine_down_counter.sv - loadable down-counter with a registered-value zero flag
module cosine_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  // Load has priority; decrement stops at zero so the flag stays stable
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/cosine_controller.sv
// rtl/cosine_controller.sv - sequencing FSM for the cosine/distance datapath
module cosine_controller #(
  parameter int ALERT_CYCLES    = 4,
  parameter int WATCHDOG_CYCLES = 32,
  parameter int STATE_W         = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               done,
  input  logic               result_ready,
  output logic [STATE_W-1:0] state,
  output logic               alert,
  output logic               busy,
  output logic               result_valid,
  output logic               error,
  output logic [3:0]         loop_count
);

  import cosine_pkg::*;

  localparam int AW = $clog2(ALERT_CYCLES + 1);
  localparam int WW = $clog2(WATCHDOG_CYCLES + 1);

  state_e state_q;
  state_e state_d;
  logic   alert_load;
  logic   alert_zero;
  logic   wd_load;
  logic   wd_zero;
  logic   in_loop;
  logic   abort;
  logic   result_valid_q;

  assign in_loop    = (state_q == ACCUM) || (state_q == REMULT);
  assign alert_load = (state_q == STANDBY) && start;
  assign wd_load    = (state_q == START_CALC);

  cosine_down_counter #(.W(AW)) u_alert_cnt (
    .clk        (clk),
    .reset      (reset),
    .load       (alert_load),
    .load_value (AW'(ALERT_CYCLES - 1)),
    .en         (state_q == ALERT),
    .zero       (alert_zero)
  );

  cosine_down_counter #(.W(WW)) u_watchdog_cnt (
    .clk        (clk),
    .reset      (reset),
    .load       (wd_load),
    .load_value (WW'(WATCHDOG_CYCLES - 1)),
    .en         (in_loop),
    .zero       (wd_zero)
  );

  // Next-state decode; a normal loop exit on stop wins over a same-cycle watchdog abort
  always_comb begin
    state_d = state_q;
    abort   = 1'b0;
    case (state_q)
      STANDBY:    if (start) state_d = ALERT;
      ALERT:      if (alert_zero) state_d = START_CALC;
      START_CALC: state_d = ACCUM;
      ACCUM: begin
        if (wd_zero) begin
          state_d = STANDBY;
          abort   = 1'b1;
        end else begin
          state_d = REMULT;
        end
      end
      REMULT: begin
        if (stop) begin
          state_d = CALC_DIST;
        end else if (wd_zero) begin
          state_d = STANDBY;
          abort   = 1'b1;
        end else begin
          state_d = ACCUM;
        end
      end
      CALC_DIST:  state_d = REPORT;
      REPORT:     if (result_valid_q && result_ready) state_d = STANDBY;
      default:    state_d = STANDBY;
    endcase
  end

  // State, loop counter, sticky error and registered result_valid
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= STANDBY;
      loop_count     <= 4'd0;
      error          <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == START_CALC) begin
        loop_count <= 4'd0;
      end else if ((state_q == ACCUM) && (loop_count != 4'hF)) begin
        loop_count <= loop_count + 4'd1;
      end
      if (alert_load) begin
        error <= 1'b0;
      end else if (abort) begin
        error <= 1'b1;
      end
      // The datapath raises done on the same edge that ends CALC_DIST, so entry into REPORT is valid
      result_valid_q <= (state_d == REPORT) && ((state_q == CALC_DIST) || done);
    end
  end

  assign state        = STATE_W'(state_q);
  assign alert        = (state_q == ALERT);
  assign busy         = (state_q != STANDBY);
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_cosine_controller.sv
// tb/tb_cosine_controller.sv - self-checking bench for cosine_controller
module tb_cosine_controller;

  localparam int ALERT_N = 4;
  localparam int WD_N    = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic       done;
  logic       result_ready;
  logic [3:0] state;
  logic       alert;
  logic       busy;
  logic       result_valid;
  logic       error;
  logic [3:0] loop_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Datapath stand-in: counts ACCUM cycles, raises stop after n_terms, done after CALC_DIST
  int   n_terms  = 8;
  bit   stop_en  = 1'b1;
  int   term_cnt = 0;
  logic done_r   = 1'b0;

  always #5 clk = ~clk;

  cosine_controller #(
    .ALERT_CYCLES    (ALERT_N),
    .WATCHDOG_CYCLES (WD_N),
    .STATE_W         (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .done         (done),
    .result_ready (result_ready),
    .state        (state),
    .alert        (alert),
    .busy         (busy),
    .result_valid (result_valid),
    .error        (error),
    .loop_count   (loop_count)
  );

  // Datapath model registers
  always @(posedge clk) begin
    if (state == 4'd2) begin
      term_cnt <= 0;
      done_r   <= 1'b0;
    end else if (state == 4'd3) begin
      term_cnt <= term_cnt + 1;
    end
    if (state == 4'd4) done_r <= 1'b1;
  end

  assign stop = stop_en && (term_cnt >= n_terms);
  assign done = done_r;

  typedef struct {
    int n;
    int delay;
    bit hold;
    int exp_lat;
    int exp_lc;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One measurement: the expected state trace comes from the run's phase lengths
  task automatic run(input int n, input int delay, input bit hold, input int exp_lat, input int exp_lc);
    int c;
    int q[$];
    q = {};
    for (int i = 0; i < ALERT_N; i++) q.push_back(1);
    q.push_back(2);
    for (int i = 0; i < n; i++) begin
      q.push_back(3);
      q.push_back(5);
    end
    q.push_back(4);
    n_terms      = n;
    stop_en      = 1'b1;
    result_ready = 1'b0;
    start        = 1'b1;
    step();
    chk("error_cleared", int'(error), 0);
    if (!hold) start = 1'b0;
    c = 0;
    while (state != 4'd6 && c < 200) begin
      chk("trace", int'(state), (c < q.size()) ? q[c] : 6);
      chk("alert_decode", int'(alert), (c < q.size() && q[c] == 1) ? 1 : 0);
      chk("busy_decode", int'(busy), 1);
      if (c < q.size() && q[c] == 4) start = 1'b0;
      step();
      c++;
    end
    start = 1'b0;
    chk("latency_model", c, q.size());
    if (exp_lat >= 0) chk("latency_table", c, exp_lat);
    chk("report_valid", int'(result_valid), 1);
    chk("loop_count", int'(loop_count), exp_lc);
    for (int i = 0; i < delay; i++) begin
      step();
      chk("hold_state", int'(state), 6);
      chk("hold_valid", int'(result_valid), 1);
    end
    result_ready = 1'b1;
    step();
    chk("handshake_state", int'(state), 0);
    chk("handshake_valid", int'(result_valid), 0);
    result_ready = 1'b0;
  endtask

  initial begin
    int c;
    bit saw_rv;
    logic [3:0] seven;
    reset        = 1'b1;
    start        = 1'b0;
    result_ready = 1'b0;
    seven        = 4'd7;
    tbl[0] = '{8, 0, 1'b0, 22, 8};
    tbl[1] = '{8, 5, 1'b0, 22, 8};
    tbl[2] = '{1, 2, 1'b1,  8, 1};
    tbl[3] = '{3, 1, 1'b0, 12, 3};

    repeat (3) step();
    chk("rst_state", int'(state), 0);
    chk("rst_alert", int'(alert), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(result_valid), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_loop_count", int'(loop_count), 0);
    reset = 1'b0;
    step();

    // Table-driven runs, including long ready stall and start held through the run
    for (int i = 0; i < 4; i++) begin
      run(tbl[i].n, tbl[i].delay, tbl[i].hold, tbl[i].exp_lat, tbl[i].exp_lc);
      step();
    end

    // Watchdog abort with stop never asserted
    stop_en = 1'b0;
    start   = 1'b1;
    step();
    start  = 1'b0;
    c      = 0;
    saw_rv = 1'b0;
    while (state != 4'd0 && c < 200) begin
      if (result_valid) saw_rv = 1'b1;
      step();
      c++;
    end
    chk("wd_abort_cycle", c, ALERT_N + 1 + WD_N);
    chk("wd_error", int'(error), 1);
    chk("wd_no_valid", int'(saw_rv), 0);
    chk("wd_loop_count_sat", int'(loop_count), 15);
    run(8, 0, 1'b0, 22, 8);

    // Reset in REMULT with three ACCUMs done
    stop_en = 1'b1;
    n_terms = 8;
    start   = 1'b1;
    step();
    start = 1'b0;
    c = 0;
    while (!(state == 4'd5 && loop_count == 4'd3) && c < 100) begin
      step();
      c++;
    end
    chk("reach_remult3", int'(c < 100), 1);
    reset = 1'b1;
    step();
    chk("midrst_state", int'(state), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_loop_count", int'(loop_count), 0);
    chk("midrst_alert", int'(alert), 0);
    reset = 1'b0;
    step();

    // Back-to-back runs with start held and ready tied high
    result_ready = 1'b1;
    start        = 1'b1;
    step();
    c = 0;
    while (state != 4'd6 && c < 100) begin
      step();
      c++;
    end
    chk("b2b_first_latency", c, 22);
    chk("b2b_valid", int'(result_valid), 1);
    step();
    chk("b2b_gap_standby", int'(state), 0);
    step();
    chk("b2b_second_alert", int'(state), 1);
    start = 1'b0;
    c = 0;
    while (state != 4'd0 && c < 100) begin
      step();
      c++;
    end
    chk("b2b_second_done", int'(c < 100), 1);
    result_ready = 1'b0;

    // Illegal state code recovers to STANDBY
    force dut.state_q = cosine_pkg::state_e'(seven);
    #1;
    release dut.state_q;
    chk("illegal_forced", int'(state), 7);
    step();
    chk("illegal_recover", int'(state), 0);
    chk("illegal_busy", int'(busy), 0);
    chk("illegal_alert", int'(alert), 0);
    chk("illegal_valid", int'(result_valid), 0);

    // Randomized runs against the phase-length model
    for (int r = 0; r < 6; r++) begin
      int idle;
      idle = $urandom_range(0, 3);
      for (int k = 0; k < idle; k++) begin
        step();
        chk("idle_standby", int'(state), 0);
      end
      begin
        int n;
        n = $urandom_range(1, 8);
        run(n, $urandom_range(0, 4), 1'($urandom_range(0, 1)), -1, n);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
